sti_deserializer: RTL and testbench
===================================

Name: sti_deserializer

Overview:
Serial-to-parallel receiver for the STI serial link: it rebuilds each 16-bit parallel word from the so_valid/so_data bit stream. It uses the same length/msb/low/fill configuration as the transmitter and checks that padding bits are zero. It sits on the far end of the serial link and feeds downstream word consumers, or a loopback checker in the contest bench.

Parameters:
none (frame widths 8/16/24/32 are fixed by the protocol)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
so_valid  in  1  serial bit strobe; high for every bit of a word
so_data  in  1  serial data bit, sampled when so_valid=1
pi_length  in  2  00=8, 01=16, 10=24, 11=32 bits per word
pi_msb  in  1  1: highest bit index first; 0: lowest first
pi_low  in  1  8-bit mode only: 1 selects byte [15:8], 0 selects byte [7:0]
pi_fill  in  1  24/32 mode: 1 places data in the upper part of the frame, 0 in the lower part
pi_end  in  1  no more words will be sent
po_data  out  16  reconstructed word
po_valid  out  1  one-cycle pulse, po_data valid
pad_err  out  1  one-cycle pulse with po_valid: a pad bit was 1
frame_err  out  1  one-cycle pulse: word truncated
word_cnt  out  8  count of completed words, wraps 255->0
rx_finish  out  1  sticky end-of-stream flag

Behaviour:
- Reset is synchronous: all outputs go to 0, state goes to IDLE, frame register is cleared, bit counter is cleared.
- States are IDLE, RECV and DONE.
- IDLE -> RECV on so_valid=1:
  - pi_length/pi_msb/pi_low/pi_fill are latched from that cycle and held for the whole word. Changes on these inputs mid-word are ignored.
  - The first bit is captured in the same cycle.
- Bit index start/end (the index steps -1 if msb=1, +1 if msb=0):
  - len8, low=1: 15..8
  - len8, low=0: 7..0
  - len16: 15..0
  - len24: 23..0
  - len32: 31..0
  - (Ranges are listed high..low; msb=0 walks them low to high.)
- Each bit with so_valid=1 is written to frame[idx]. A 5-bit counter counts received bits.
- Word completion is at the edge that samples bit L, where L is the word length. At that edge, registered on the same edge:
  - po_valid=1
  - po_data is loaded with the extraction below
  - pad_err is set
  - word_cnt increments
- Extraction into po_data:
  - len8: the selected byte goes to its position; the other byte is 0.
  - len16: frame[15:0].
  - len24, fill=1: frame[23:8]; pad bits are frame[7:0].
  - len24, fill=0: frame[15:0]; pad bits are frame[23:16].
  - len32, fill=1: frame[31:16]; pad bits are frame[15:0].
  - len32, fill=0: frame[15:0]; pad bits are frame[31:16].
  - pad_err = OR of the pad bits.
- po_data holds its value until the next completion. po_valid, pad_err and frame_err are single-cycle pulses.
- Back-to-back words: if so_valid stays 1 in the cycle after completion, that bit starts a new word. Config is re-latched then, and the state stays RECV. If so_valid=0, the state returns to IDLE.
- The frame register is cleared at each word start, so bits from a previous word do not leak into the next.
- Truncation: so_valid=0 while in RECV with fewer than L bits received causes:
  - frame_err pulse next edge
  - no po_valid
  - word_cnt unchanged
  - return to IDLE
- pi_end=1 while in IDLE with so_valid=0: go to DONE, rx_finish=1.
  - DONE is terminal until reset; so_valid is ignored there.
  - pi_end while in RECV is ignored until the word completes or truncates, and is acted on once back in IDLE.
- Reset mid-word discards the partial word; no pulses are emitted.

Test Plan:
- len16, msb=1: send 0xA5C3 MSB-first (16 valid cycles) -> po_valid on the 16th sampling edge, po_data=0xA5C3, pad_err=0, word_cnt=1.
- len8, low=1, msb=0: send byte 0x5A LSB-first -> po_data=0x5A00. Then len8, low=0, msb=1, byte 0x3C -> po_data=0x003C, word_cnt=2.
- len32, fill=1, msb=1: send 0x1234 followed by 16 zeros -> po_data=0x1234, pad_err=0. Repeat with the 20th bit=1 -> pad_err=1 together with po_valid.
- len24, fill=0, msb=0, back-to-back with len16 (so_valid never drops for 40 cycles) -> two po_valid pulses 16 cycles apart with correct data, no frame_err.
- len16: drop so_valid after 5 bits -> frame_err pulse, no po_valid, word_cnt unchanged. A following full word is received correctly.
- Assert reset mid-word, then pi_end=1 in IDLE -> all outputs 0 after reset, then rx_finish=1 and held; later so_valid activity produces no po_valid.

Source files
------------

// File: rtl/sti_deserializer.sv
// STI serial link receiver: rebuilds 16-bit words from the so_valid/so_data bit stream,
// honouring the length/msb/low/fill frame configuration and flagging non-zero pad bits.
module sti_deserializer (
   input  logic        clk,
   input  logic        reset,
   input  logic        so_valid,
   input  logic        so_data,
   input  logic [1:0]  pi_length,
   input  logic        pi_msb,
   input  logic        pi_low,
   input  logic        pi_fill,
   input  logic        pi_end,
   output logic [15:0] po_data,
   output logic        po_valid,
   output logic        pad_err,
   output logic        frame_err,
   output logic [7:0]  word_cnt,
   output logic        rx_finish
);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t      state, state_n;
   logic [31:0] frame, frame_n, frame_base;
   logic [4:0]  cnt, cnt_n;
   logic [1:0]  len_q, len_n;
   logic        msb_q, msb_n, low_q, low_n, fill_q, fill_n;
   logic [15:0] po_data_n;
   logic        po_valid_n, pad_err_n, frame_err_n, rx_finish_n;
   logic [7:0]  word_cnt_n;

   logic        start, take;
   logic [1:0]  cur_len;
   logic        cur_msb, cur_low, cur_fill;
   logic [4:0]  last_cnt, lo_idx, idx;

   // In RECV a zero bit count means the previous word just completed, so a valid bit opens a new word.
   assign start    = so_valid && ((state == IDLE) || ((state == RECV) && (cnt == 5'd0)));
   assign cur_len  = start ? pi_length : len_q;
   assign cur_msb  = start ? pi_msb    : msb_q;
   assign cur_low  = start ? pi_low    : low_q;
   assign cur_fill = start ? pi_fill   : fill_q;
   assign last_cnt = {cur_len, 3'b111};
   assign lo_idx   = ((cur_len == 2'b00) && cur_low) ? 5'd8 : 5'd0;
   assign idx      = cur_msb ? (lo_idx + last_cnt - cnt) : (lo_idx + cnt);
   assign frame_base = start ? 32'd0 : frame;

   always_comb begin
      state_n     = state;
      frame_n     = frame;
      cnt_n       = cnt;
      len_n       = len_q;
      msb_n       = msb_q;
      low_n       = low_q;
      fill_n      = fill_q;
      po_data_n   = po_data;
      po_valid_n  = 1'b0;
      pad_err_n   = 1'b0;
      frame_err_n = 1'b0;
      word_cnt_n  = word_cnt;
      rx_finish_n = rx_finish;
      take        = 1'b0;

      case (state)
         IDLE: begin
            if (so_valid) begin
               take = 1'b1;
            end else if (pi_end) begin
               state_n     = DONE;
               rx_finish_n = 1'b1;
            end
         end
         RECV: begin
            if (so_valid) begin
               take = 1'b1;
            end else begin
               frame_err_n = (cnt != 5'd0);
               state_n     = IDLE;
               cnt_n       = 5'd0;
            end
         end
         DONE: begin
            state_n = DONE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (take) begin
         state_n      = RECV;
         frame_n      = frame_base;
         frame_n[idx] = so_data;
         cnt_n        = cnt + 5'd1;
         if (start) begin
            len_n  = pi_length;
            msb_n  = pi_msb;
            low_n  = pi_low;
            fill_n = pi_fill;
         end
         // Completion uses the frame including the bit sampled on this edge.
         if (cnt == last_cnt) begin
            cnt_n      = 5'd0;
            po_valid_n = 1'b1;
            word_cnt_n = word_cnt + 8'd1;
            case (cur_len)
               2'b00: po_data_n = cur_low ? {frame_n[15:8], 8'h00} : {8'h00, frame_n[7:0]};
               2'b01: po_data_n = frame_n[15:0];
               2'b10: begin
                  po_data_n = cur_fill ? frame_n[23:8] : frame_n[15:0];
                  pad_err_n = cur_fill ? (|frame_n[7:0]) : (|frame_n[23:16]);
               end
               default: begin
                  po_data_n = cur_fill ? frame_n[31:16] : frame_n[15:0];
                  pad_err_n = cur_fill ? (|frame_n[15:0]) : (|frame_n[31:16]);
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         frame     <= 32'd0;
         cnt       <= 5'd0;
         len_q     <= 2'b00;
         msb_q     <= 1'b0;
         low_q     <= 1'b0;
         fill_q    <= 1'b0;
         po_data   <= 16'd0;
         po_valid  <= 1'b0;
         pad_err   <= 1'b0;
         frame_err <= 1'b0;
         word_cnt  <= 8'd0;
         rx_finish <= 1'b0;
      end else begin
         state     <= state_n;
         frame     <= frame_n;
         cnt       <= cnt_n;
         len_q     <= len_n;
         msb_q     <= msb_n;
         low_q     <= low_n;
         fill_q    <= fill_n;
         po_data   <= po_data_n;
         po_valid  <= po_valid_n;
         pad_err   <= pad_err_n;
         frame_err <= frame_err_n;
         word_cnt  <= word_cnt_n;
         rx_finish <= rx_finish_n;
      end
   end

endmodule

// File: tb/tb_sti_deserializer.sv
// Bench for sti_deserializer: builds a cycle schedule of serialized words from chosen data/pad values
// and compares every cycle's outputs against the expected words derived from that schedule.
module tb_sti_deserializer;

   localparam int MAXC = 4000;

   logic        clk = 1'b0;
   logic        reset, so_valid, so_data;
   logic [1:0]  pi_length;
   logic        pi_msb, pi_low, pi_fill, pi_end;
   logic [15:0] po_data;
   logic        po_valid, pad_err, frame_err, rx_finish;
   logic [7:0]  word_cnt;

   bit          drv_v[MAXC];
   bit          drv_d[MAXC];
   logic [4:0]  drv_cfg[MAXC];
   bit          exp_v[MAXC];
   bit          exp_pad[MAXC];
   bit          exp_ferr[MAXC];
   logic [15:0] exp_word[MAXC];
   int          ncyc = 0;
   int          check_count = 0;
   int          error_count = 0;
   logic [15:0] cur_data;
   logic [7:0]  cur_cnt;

   sti_deserializer dut (
      .clk(clk), .reset(reset), .so_valid(so_valid), .so_data(so_data),
      .pi_length(pi_length), .pi_msb(pi_msb), .pi_low(pi_low), .pi_fill(pi_fill), .pi_end(pi_end),
      .po_data(po_data), .po_valid(po_valid), .pad_err(pad_err), .frame_err(frame_err),
      .word_cnt(word_cnt), .rx_finish(rx_finish)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Places data/pad into the frame layout, then serializes nbits of it; a short word is followed by a drop.
   task automatic addWord(input logic [1:0] len, input bit msb, input bit low, input bit fill,
                          input logic [15:0] data, input logic [15:0] pad, input int nbits, input int gap);
      int          blen, lo, pos;
      logic [31:0] f;
      logic [15:0] word, p;
      blen = 8 * (int'(len) + 1);
      lo   = (len == 2'b00 && low) ? 8 : 0;
      word = data;
      p    = pad;
      case (len)
         2'b00: begin
            f    = low ? {16'h0, data[7:0], 8'h00} : {24'h0, data[7:0]};
            word = low ? {data[7:0], 8'h00} : {8'h00, data[7:0]};
            p    = 16'h0;
         end
         2'b01: begin
            f = {16'h0, data};
            p = 16'h0;
         end
         2'b10: begin
            f = fill ? {8'h0, data, pad[7:0]} : {8'h0, pad[7:0], data};
            p = {8'h0, pad[7:0]};
         end
         default: f = fill ? {data, pad} : {pad, data};
      endcase
      for (int k = 0; k < nbits; k++) begin
         pos = msb ? (lo + blen - 1 - k) : (lo + k);
         drv_v[ncyc] = 1'b1;
         drv_d[ncyc] = f[pos];
         if (k == 0) drv_cfg[ncyc] = {len, msb, low, fill};
         ncyc++;
      end
      if (nbits == blen) begin
         exp_v[ncyc-1]    = 1'b1;
         exp_word[ncyc-1] = word;
         exp_pad[ncyc-1]  = (p != 16'h0);
      end else begin
         drv_v[ncyc]    = 1'b0;
         exp_ferr[ncyc] = 1'b1;
         ncyc++;
      end
      ncyc += gap;
   endtask

   task automatic applyStimulus(input int c);
      so_valid = drv_v[c];
      so_data  = drv_d[c];
      {pi_length, pi_msb, pi_low, pi_fill} = drv_cfg[c];
      pi_end   = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < MAXC; i++) begin
         drv_v[i]    = 1'b0;
         drv_d[i]    = 1'($urandom);
         drv_cfg[i]  = 5'($urandom);
         exp_v[i]    = 1'b0;
         exp_pad[i]  = 1'b0;
         exp_ferr[i] = 1'b0;
         exp_word[i] = 16'h0;
      end

      addWord(2'd1, 1, 0, 0, 16'hA5C3, 16'h0000, 16, 2);
      addWord(2'd0, 0, 1, 0, 16'h005A, 16'h0000, 8, 1);
      addWord(2'd0, 1, 0, 0, 16'h003C, 16'h0000, 8, 1);
      addWord(2'd3, 1, 0, 1, 16'h1234, 16'h0000, 32, 1);
      addWord(2'd3, 1, 0, 1, 16'h1234, 16'h1000, 32, 1);
      addWord(2'd2, 0, 0, 0, 16'hBEEF, 16'h0000, 24, 0);
      addWord(2'd1, 1, 0, 0, 16'h7E81, 16'h0000, 16, 1);
      addWord(2'd1, 1, 0, 0, 16'hFFFF, 16'h0000, 5, 0);
      addWord(2'd1, 0, 0, 0, 16'h1357, 16'h0000, 16, 2);
      for (int w = 0; w < 60; w++) begin
         logic [1:0]  len;
         logic [15:0] pad;
         int          blen, nb;
         len  = 2'($urandom_range(0, 3));
         blen = 8 * (int'(len) + 1);
         pad  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
         nb   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, blen - 1) : blen;
         addWord(len, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), pad, nb,
                 $urandom_range(0, 2));
      end
      ncyc += 3;

      reset = 1'b1; so_valid = 1'b0; so_data = 1'b0;
      pi_length = 2'b00; pi_msb = 1'b0; pi_low = 1'b0; pi_fill = 1'b0; pi_end = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_po_data", 32'(po_data), 32'h0);
      checkOutput("reset_po_valid", 32'(po_valid), 32'h0);
      checkOutput("reset_pad_err", 32'(pad_err), 32'h0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
      checkOutput("reset_word_cnt", 32'(word_cnt), 32'h0);
      checkOutput("reset_rx_finish", 32'(rx_finish), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      cur_data = 16'h0;
      cur_cnt  = 8'h0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         applyStimulus(c);
         @(posedge clk);
         #1;
         if (exp_v[c]) begin
            cur_data = exp_word[c];
            cur_cnt  = cur_cnt + 8'd1;
         end
         checkOutput("po_valid", 32'(po_valid), 32'(exp_v[c]));
         checkOutput("pad_err", 32'(pad_err), 32'(exp_pad[c]));
         checkOutput("frame_err", 32'(frame_err), 32'(exp_ferr[c]));
         checkOutput("po_data", 32'(po_data), 32'(cur_data));
         checkOutput("word_cnt", 32'(word_cnt), 32'(cur_cnt));
         checkOutput("rx_finish", 32'(rx_finish), 32'h0);
      end

      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         so_valid = 1'b1; so_data = 1'($urandom);
         pi_length = 2'b01; pi_msb = 1'b1; pi_end = 1'b0;
      end
      @(negedge clk);
      reset = 1'b1; so_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midreset_po_data", 32'(po_data), 32'h0);
      checkOutput("midreset_po_valid", 32'(po_valid), 32'h0);
      checkOutput("midreset_frame_err", 32'(frame_err), 32'h0);
      checkOutput("midreset_word_cnt", 32'(word_cnt), 32'h0);
      checkOutput("midreset_rx_finish", 32'(rx_finish), 32'h0);
      @(negedge clk);
      reset = 1'b0; so_valid = 1'b0; pi_end = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("end_rx_finish", 32'(rx_finish), 32'h1);
      checkOutput("end_frame_err", 32'(frame_err), 32'h0);

      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         so_valid = 1'($urandom); so_data = 1'($urandom); pi_end = 1'($urandom);
         {pi_length, pi_msb, pi_low, pi_fill} = 5'($urandom);
         @(posedge clk);
         #1;
         checkOutput("done_po_valid", 32'(po_valid), 32'h0);
         checkOutput("done_frame_err", 32'(frame_err), 32'h0);
         checkOutput("done_word_cnt", 32'(word_cnt), 32'h0);
         checkOutput("done_rx_finish", 32'(rx_finish), 32'h1);
      end

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
